multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Moore FSM sequencing a shared-memory, multi-cycle MIPS datapath (one ALU, one memory port, IR/PC regs).
//  Decodes the IR contents and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  Drives every datapath mux select and write enable.
//  Stalls on a memory ready handshake.
//  Supports lw, sw, R-type (add/sub/and/or/slt/jr), addi, beq, bne, j.
// PARAMETERS
//  none (opcode/funct encodings are standard MIPS-I, fixed)
// PORTS
//  clk          in   1   system clock, single clock domain; all state updates on posedge
//  reset        in   1   synchronous, active-high reset
//  instr        in   32  instruction register contents; op=instr[31:26], funct=instr[5:0]
//  zero         in   1   ALU zero flag (valid in BRANCH state)
//  mem_ready    in   1   memory has completed the current read/write this cycle
//  iord         out  1   address mux: 0=PC, 1=ALUOut
//  irwrite      out  1   load IR from memory read data
//  memwrite     out  1   memory write request
//  regdst       out  1   write reg: 0=rt, 1=rd
//  memtoreg     out  1   write data: 0=ALUOut, 1=MDR
//  regwrite     out  1   register file write enable
//  alusrca      out  1   ALU A: 0=PC, 1=rs
//  alusrcb      out  2   ALU B: 00=rt, 01=4, 10=signimm, 11=signimm<<2
//  alucontrol   out  4   0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt
//  pcsrc        out  2   next PC: 00=ALUResult, 01=ALUOut, 10=jump target, 11=rs (jr)
//  pcen         out  1   PC load enable (includes resolved branch condition)
//  illegal_op   out  1   one-cycle pulse: unsupported opcode/funct detected in DECODE
// BEHAVIOUR
//  States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, JR.
//  Reset: state<=FETCH; while reset=1 all enables (irwrite,memwrite,regwrite,pcen) forced 0, illegal_op=0.
//  Default outputs (all states): every enable 0, iord=0, regdst=0, memtoreg=0, alusrca=0, alusrcb=00,
//   alucontrol=0010, pcsrc=00; each state overrides only what is listed below.
//  FETCH: iord=0, alusrca=0, alusrcb=01, add, pcsrc=00; irwrite=pcen=mem_ready.
//   Stay while mem_ready=0; ->DECODE when 1. PC/IR never load on a stalled cycle.
//  DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next by op:
//   100011/101011->MEMADR; 000000->EXECUTE (funct 001000 ->JR); 001000->ADDIEX;
//   000100/000101->BRANCH; 000010->JUMP; other op or unsupported R funct ->FETCH with illegal_op=1.
//  MEMADR: alusrca=1, alusrcb=10, add; ->MEMRD (lw) or MEMWR (sw).
//  MEMRD: iord=1; wait mem_ready; ->MEMWB.
//  MEMWB: regdst=0, memtoreg=1, regwrite=1; ->FETCH.
//  MEMWR: iord=1, memwrite=1 held until mem_ready=1; ->FETCH on that cycle.
//  EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct
//   (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt); ->ALUWB.
//  ALUWB: regdst=1, memtoreg=0, regwrite=1; ->FETCH.
//  ADDIEX: alusrca=1, alusrcb=10, add; ->ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; ->FETCH.
//  BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01; pcen=(op==000100)?zero:~zero (combinational); ->FETCH.
//  JUMP: pcsrc=10, pcen=1; ->FETCH. JR: pcsrc=11, pcen=1; ->FETCH.
//  Latency with mem_ready=1 throughout (cycles incl. FETCH): lw 5, sw 4, R 4, addi 4, beq/bne 3, j/jr 3.
//  Each memory wait adds 1 cycle per mem_ready=0 cycle; outputs stay constant during the wait.
//  Reset mid-instruction: next cycle in FETCH; no regwrite/memwrite/pcen issued in the reset cycle.
//  Every state has exactly one successor per input combination; unreachable encodings ->FETCH.
// TESTING
//  1. reset=1 for 2 cycles, mem_ready=1 -> state FETCH; irwrite,pcen,regwrite,memwrite all 0 during reset.
//  2. lw 0x8C080004, mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB (5 cycles);
//     regwrite=1 only in MEMWB, with memtoreg=1 and regdst=0.
//  3. sw with mem_ready low 3 cycles in MEMWR -> memwrite high 4 cycles, then FETCH; no regwrite.
//  4. beq zero=1 -> pcen=1 with pcsrc=01 in BRANCH; bne zero=1 -> pcen=0; bne zero=0 -> pcen=1.
//  5. R sub (funct 100010) -> alucontrol=0110 in EXECUTE; ALUWB regdst=1; jr (funct 001000) -> JR, pcsrc=11.
//  6. op 111111 -> illegal_op=1 for one cycle in DECODE, then FETCH; no write enable asserted.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Purpose: control/status bundle between the multi-cycle MIPS controller and its datapath.
// Latency: none (plain wires); the controller drives every output combinationally from its state.
// Backpressure: mem_ready from the datapath side stalls the controller in FETCH/MEMRD/MEMWR.
//
// Signals:
//   instr      IR contents (op = instr[31:26], funct = instr[5:0])
//   zero       ALU zero flag, meaningful in BRANCH
//   mem_ready  memory finished the current read/write this cycle
//   iord, irwrite, memwrite, regdst, memtoreg, regwrite, alusrca,
//   alusrcb, alucontrol, pcsrc, pcen  datapath selects and enables
//   illegal_op one-cycle pulse in DECODE for an unsupported opcode/funct
interface multicycle_controller_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;

    logic        iord;
    logic        irwrite;
    logic        memwrite;
    logic        regdst;
    logic        memtoreg;
    logic        regwrite;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [3:0]  alucontrol;
    logic [1:0]  pcsrc;
    logic        pcen;
    logic        illegal_op;

    // controller side
    modport master (
        input  instr, zero, mem_ready,
        output iord, irwrite, memwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal_op
    );

    // datapath side
    modport slave (
        output instr, zero, mem_ready,
        input  iord, irwrite, memwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, alucontrol, pcsrc, pcen, illegal_op
    );
endinterface

// File: rtl/multicycle_controller.sv
// Purpose: Moore FSM sequencing a shared-memory multi-cycle MIPS datapath (lw/sw/R/addi/beq/bne/j/jr).
// Latency: lw 5, sw/R/addi 4, beq/bne/j/jr 3 cycles incl. FETCH; +1 cycle per mem_ready=0 cycle.
// Backpressure: FETCH, MEMRD and MEMWR hold state and outputs while mem_ready=0; PC/IR never load then.
//
// Ports:
//   clk    single clock, all state updates on posedge
//   reset  synchronous active-high; returns to FETCH and forces all enables/illegal_op low
//   bus    multicycle_controller_if.master (instr/zero/mem_ready in, datapath controls out)
module multicycle_controller (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_controller_if.master    bus
);

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_JR  = 6'b001000;

    // ALU operations
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // FSM states
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXECUTE = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_ADDIEX  = 4'd8;
    localparam logic [3:0] S_ADDIWB  = 4'd9;
    localparam logic [3:0] S_BRANCH  = 4'd10;
    localparam logic [3:0] S_JUMP    = 4'd11;
    localparam logic [3:0] S_JR      = 4'd12;

    logic [3:0] state;
    logic [3:0] next_state;

    logic [5:0] op;
    logic [5:0] funct;
    assign op    = bus.instr[31:26];
    assign funct = bus.instr[5:0];

    // Register fields are consumed by the datapath, not by the controller.
    logic unused_instr_bits;
    assign unused_instr_bits = ^bus.instr[25:6];

    // R-type funct decode: legality and the ALU operation it selects.
    // jr is legal but never reaches EXECUTE, so its ALU code is irrelevant.
    logic       rtype_ok;
    logic [3:0] rtype_alu;

    always_comb begin
        rtype_ok  = 1'b1;
        rtype_alu = ALU_ADD;
        case (funct)
            F_ADD:   rtype_alu = ALU_ADD;
            F_SUB:   rtype_alu = ALU_SUB;
            F_AND:   rtype_alu = ALU_AND;
            F_OR:    rtype_alu = ALU_OR;
            F_SLT:   rtype_alu = ALU_SLT;
            F_JR:    rtype_alu = ALU_ADD;
            default: rtype_ok  = 1'b0;
        endcase
    end

    // Opcode legality, used for the illegal_op pulse in DECODE.
    logic op_ok;

    always_comb begin
        case (op)
            OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_BNE, OP_J: op_ok = 1'b1;
            OP_RTYPE:                                    op_ok = rtype_ok;
            default:                                     op_ok = 1'b0;
        endcase
    end

    // Next-state logic
    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:   next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct == F_JR)
                            next_state = S_JR;
                        else if (rtype_ok)
                            next_state = S_EXECUTE;
                        else
                            next_state = S_FETCH;
                    end
                    OP_ADDI:        next_state = S_ADDIEX;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_J:           next_state = S_JUMP;
                    default:        next_state = S_FETCH;
                endcase
            end
            // Only lw/sw can reach MEMADR, so op bit 3 separates them.
            S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   next_state = S_FETCH;
            S_MEMWR:   next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXECUTE: next_state = S_ALUWB;
            S_ALUWB:   next_state = S_FETCH;
            S_ADDIEX:  next_state = S_ADDIWB;
            S_ADDIWB:  next_state = S_FETCH;
            S_BRANCH:  next_state = S_FETCH;
            S_JUMP:    next_state = S_FETCH;
            S_JR:      next_state = S_FETCH;
            default:   next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    // Output decode. Moore except for the mem_ready qualification of the
    // FETCH loads and the zero-dependent branch enable.
    logic       o_iord;
    logic       o_irwrite;
    logic       o_memwrite;
    logic       o_regdst;
    logic       o_memtoreg;
    logic       o_regwrite;
    logic       o_alusrca;
    logic [1:0] o_alusrcb;
    logic [3:0] o_alucontrol;
    logic [1:0] o_pcsrc;
    logic       o_pcen;
    logic       o_illegal;

    always_comb begin
        o_iord       = 1'b0;
        o_irwrite    = 1'b0;
        o_memwrite   = 1'b0;
        o_regdst     = 1'b0;
        o_memtoreg   = 1'b0;
        o_regwrite   = 1'b0;
        o_alusrca    = 1'b0;
        o_alusrcb    = 2'b00;
        o_alucontrol = ALU_ADD;
        o_pcsrc      = 2'b00;
        o_pcen       = 1'b0;
        o_illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                // PC+4 computed every FETCH cycle, but only committed with the IR load.
                o_alusrcb = 2'b01;
                o_irwrite = bus.mem_ready;
                o_pcen    = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while the register file is read.
                o_alusrcb = 2'b11;
                o_illegal = ~op_ok;
            end
            S_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                o_iord = 1'b1;
            end
            S_MEMWB: begin
                o_memtoreg = 1'b1;
                o_regwrite = 1'b1;
            end
            S_MEMWR: begin
                o_iord     = 1'b1;
                o_memwrite = 1'b1;
            end
            S_EXECUTE: begin
                o_alusrca    = 1'b1;
                o_alucontrol = rtype_alu;
            end
            S_ALUWB: begin
                o_regdst   = 1'b1;
                o_regwrite = 1'b1;
            end
            S_ADDIEX: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                o_regwrite = 1'b1;
            end
            S_BRANCH: begin
                o_alusrca    = 1'b1;
                o_alucontrol = ALU_SUB;
                o_pcsrc      = 2'b01;
                o_pcen       = (op == OP_BEQ) ? bus.zero : ~bus.zero;
            end
            S_JUMP: begin
                o_pcsrc = 2'b10;
                o_pcen  = 1'b1;
            end
            S_JR: begin
                o_pcsrc = 2'b11;
                o_pcen  = 1'b1;
            end
            default: begin
            end
        endcase

        // No architectural side effect may escape during a reset cycle.
        if (reset) begin
            o_irwrite  = 1'b0;
            o_memwrite = 1'b0;
            o_regwrite = 1'b0;
            o_pcen     = 1'b0;
            o_illegal  = 1'b0;
        end
    end

    assign bus.iord       = o_iord;
    assign bus.irwrite    = o_irwrite;
    assign bus.memwrite   = o_memwrite;
    assign bus.regdst     = o_regdst;
    assign bus.memtoreg   = o_memtoreg;
    assign bus.regwrite   = o_regwrite;
    assign bus.alusrca    = o_alusrca;
    assign bus.alusrcb    = o_alusrcb;
    assign bus.alucontrol = o_alucontrol;
    assign bus.pcsrc      = o_pcsrc;
    assign bus.pcen       = o_pcen;
    assign bus.illegal_op = o_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instruction sequences, per-cycle
// expected control words queued by the stimulus and checked by an independent monitor.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [3:0] alucontrol;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal_op;
    } ctl_t;

    ctl_t  exp_q  [$];
    ctl_t  mask_q [$];
    string name_q [$];

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- expected control words, one per state ----------------
    function automatic ctl_t dflt();
        ctl_t c;
        c            = '0;
        c.alucontrol = 4'b0010;
        return c;
    endfunction

    function automatic ctl_t e_fetch(input logic mr);
        ctl_t c = dflt();
        c.alusrcb = 2'b01;
        c.irwrite = mr;
        c.pcen    = mr;
        return c;
    endfunction

    function automatic ctl_t e_decode(input logic ill);
        ctl_t c = dflt();
        c.alusrcb    = 2'b11;
        c.illegal_op = ill;
        return c;
    endfunction

    function automatic ctl_t e_memadr();
        ctl_t c = dflt();
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
        return c;
    endfunction

    function automatic ctl_t e_memrd();
        ctl_t c = dflt();
        c.iord = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_memwb(input logic we);
        ctl_t c = dflt();
        c.memtoreg = 1'b1;
        c.regwrite = we;
        return c;
    endfunction

    function automatic ctl_t e_memwr(input logic we);
        ctl_t c = dflt();
        c.iord     = 1'b1;
        c.memwrite = we;
        return c;
    endfunction

    function automatic ctl_t e_execute(input logic [3:0] alu);
        ctl_t c = dflt();
        c.alusrca    = 1'b1;
        c.alucontrol = alu;
        return c;
    endfunction

    function automatic ctl_t e_aluwb();
        ctl_t c = dflt();
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_addiwb();
        ctl_t c = dflt();
        c.regwrite = 1'b1;
        return c;
    endfunction

    function automatic ctl_t e_branch(input logic taken);
        ctl_t c = dflt();
        c.alusrca    = 1'b1;
        c.alucontrol = 4'b0110;
        c.pcsrc      = 2'b01;
        c.pcen       = taken;
        return c;
    endfunction

    function automatic ctl_t e_jump(input logic [1:0] src);
        ctl_t c = dflt();
        c.pcsrc = src;
        c.pcen  = 1'b1;
        return c;
    endfunction

    ctl_t m_all;
    ctl_t m_en;

    // ---------------- stimulus: one call per clock cycle ----------------
    task automatic cyc(input logic [31:0] i, input logic z, input logic mr,
                       input logic rst, input ctl_t e, input ctl_t m, input string n);
        bus.instr     = i;
        bus.zero      = z;
        bus.mem_ready = mr;
        reset         = rst;
        exp_q.push_back(e);
        mask_q.push_back(m);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input logic [31:0] i, input logic ill);
        cyc(i, 1'b0, 1'b1, 1'b0, e_fetch(1'b1), m_all, "fetch");
        cyc(i, 1'b0, 1'b1, 1'b0, e_decode(ill), m_all, "decode");
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        ctl_t act, e, m;
        string n;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                m = mask_q.pop_front();
                n = name_q.pop_front();
                act = '{bus.iord, bus.irwrite, bus.memwrite, bus.regdst, bus.memtoreg,
                        bus.regwrite, bus.alusrca, bus.alusrcb, bus.alucontrol,
                        bus.pcsrc, bus.pcen, bus.illegal_op};
                vectors++;
                if (((act ^ e) & m) != '0) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got %h, want %h (mask %h)", n, $time, act, e, m);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d entries pending", exp_q.size());
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    logic [5:0]  rfn [5];
    logic [3:0]  ral [5];
    logic [31:0] ins;

    initial begin
        ctl_t rst_fetch;

        m_all            = '1;
        m_en             = '0;
        m_en.irwrite     = 1'b1;
        m_en.memwrite    = 1'b1;
        m_en.regwrite    = 1'b1;
        m_en.pcen        = 1'b1;
        m_en.illegal_op  = 1'b1;

        rfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ral = '{4'b0010,   4'b0110,   4'b0000,   4'b0001,   4'b0111};

        bus.instr     = 32'h0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        reset         = 1'b1;
        @(posedge clk);
        #1;

        // Reset: state unknown in the first cycle, so only enables are checked;
        // second cycle is FETCH with its loads suppressed.
        rst_fetch         = e_fetch(1'b1);
        rst_fetch.irwrite = 1'b0;
        rst_fetch.pcen    = 1'b0;
        cyc(32'h0, 1'b0, 1'b1, 1'b1, dflt(), m_en, "reset0_enables");
        cyc(32'h0, 1'b0, 1'b1, 1'b1, rst_fetch, m_all, "reset1_fetch");

        // lw, no waits: 5 cycles
        fetch_decode(32'h8C080004, 1'b0);
        cyc(32'h8C080004, 1'b0, 1'b1, 1'b0, e_memadr(),     m_all, "lw_memadr");
        cyc(32'h8C080004, 1'b0, 1'b1, 1'b0, e_memrd(),      m_all, "lw_memrd");
        cyc(32'h8C080004, 1'b0, 1'b1, 1'b0, e_memwb(1'b1),  m_all, "lw_memwb");

        // lw with a fetch stall and a read stall
        cyc(32'h8C090008, 1'b0, 1'b0, 1'b0, e_fetch(1'b0),  m_all, "fetch_stall");
        fetch_decode(32'h8C090008, 1'b0);
        cyc(32'h8C090008, 1'b0, 1'b1, 1'b0, e_memadr(),     m_all, "lw2_memadr");
        cyc(32'h8C090008, 1'b0, 1'b0, 1'b0, e_memrd(),      m_all, "lw2_memrd_stall");
        cyc(32'h8C090008, 1'b0, 1'b1, 1'b0, e_memrd(),      m_all, "lw2_memrd");
        cyc(32'h8C090008, 1'b0, 1'b1, 1'b0, e_memwb(1'b1),  m_all, "lw2_memwb");

        // sw with mem_ready low for 3 cycles in MEMWR: memwrite held 4 cycles
        fetch_decode(32'hAC080004, 1'b0);
        cyc(32'hAC080004, 1'b0, 1'b1, 1'b0, e_memadr(),     m_all, "sw_memadr");
        for (int k = 0; k < 3; k++)
            cyc(32'hAC080004, 1'b0, 1'b0, 1'b0, e_memwr(1'b1), m_all, "sw_memwr_stall");
        cyc(32'hAC080004, 1'b0, 1'b1, 1'b0, e_memwr(1'b1),  m_all, "sw_memwr_done");

        // R-type ALU ops
        for (int k = 0; k < 5; k++) begin
            ins = {6'b000000, 5'd8, 5'd9, 5'd10, 5'd0, rfn[k]};
            fetch_decode(ins, 1'b0);
            cyc(ins, 1'b0, 1'b1, 1'b0, e_execute(ral[k]), m_all, "r_execute");
            cyc(ins, 1'b0, 1'b1, 1'b0, e_aluwb(),         m_all, "r_aluwb");
        end

        // jr
        fetch_decode(32'h01000008, 1'b0);
        cyc(32'h01000008, 1'b0, 1'b1, 1'b0, e_jump(2'b11), m_all, "jr");

        // addi
        fetch_decode(32'h21080005, 1'b0);
        cyc(32'h21080005, 1'b0, 1'b1, 1'b0, e_memadr(),    m_all, "addi_ex");
        cyc(32'h21080005, 1'b0, 1'b1, 1'b0, e_addiwb(),    m_all, "addi_wb");

        // beq / bne, both zero polarities
        fetch_decode(32'h11090003, 1'b0);
        cyc(32'h11090003, 1'b1, 1'b1, 1'b0, e_branch(1'b1), m_all, "beq_z1");
        fetch_decode(32'h11090003, 1'b0);
        cyc(32'h11090003, 1'b0, 1'b1, 1'b0, e_branch(1'b0), m_all, "beq_z0");
        fetch_decode(32'h15090003, 1'b0);
        cyc(32'h15090003, 1'b1, 1'b1, 1'b0, e_branch(1'b0), m_all, "bne_z1");
        fetch_decode(32'h15090003, 1'b0);
        cyc(32'h15090003, 1'b0, 1'b1, 1'b0, e_branch(1'b1), m_all, "bne_z0");

        // j
        fetch_decode(32'h08000010, 1'b0);
        cyc(32'h08000010, 1'b0, 1'b1, 1'b0, e_jump(2'b10), m_all, "j");

        // illegal opcode and illegal R funct: pulse in DECODE, straight back to FETCH
        fetch_decode(32'hFC000000, 1'b1);
        fetch_decode(32'h0109503F, 1'b1);

        // reset in MEMWB: write suppressed, next cycle FETCH
        fetch_decode(32'h8C080004, 1'b0);
        cyc(32'h8C080004, 1'b0, 1'b1, 1'b0, e_memadr(),     m_all, "lwr_memadr");
        cyc(32'h8C080004, 1'b0, 1'b1, 1'b0, e_memrd(),      m_all, "lwr_memrd");
        cyc(32'h8C080004, 1'b0, 1'b1, 1'b1, e_memwb(1'b0),  m_all, "lwr_reset_memwb");

        // reset in MEMWR: memwrite suppressed, next cycle FETCH
        fetch_decode(32'hAC080004, 1'b0);
        cyc(32'hAC080004, 1'b0, 1'b1, 1'b0, e_memadr(),     m_all, "swr_memadr");
        cyc(32'hAC080004, 1'b0, 1'b0, 1'b1, e_memwr(1'b0),  m_all, "swr_reset_memwr");
        cyc(32'h00000000, 1'b0, 1'b1, 1'b0, e_fetch(1'b1),  m_all, "after_reset_fetch");

        // Drain and confirm the monitor consumed every expectation.
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
